// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse keyer: FSM states, element timing
// in units, and the character lookup record.
package morse_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        MARK  = 3'd2,
        SPACE = 3'd3,
        GAP   = 3'd4,
        WORD  = 3'd5
    } state_e;

    localparam int DOT_UNITS      = 1;
    localparam int DASH_UNITS     = 3;
    localparam int ELEM_GAP_UNITS = 1;
    localparam int MAX_ELEMS      = 5;

    // pattern is left-aligned: pattern[4] is the first element, 1 = dash
    typedef struct packed {
        logic       valid;
        logic       is_space;
        logic [2:0] len;
        logic [4:0] pattern;
    } morse_rec_t;

    function automatic morse_rec_t morse_sym(input logic [2:0] len, input logic [4:0] pat);
        morse_rec_t r;
        r.valid    = 1'b1;
        r.is_space = 1'b0;
        r.len      = len;
        r.pattern  = pat;
        return r;
    endfunction

endpackage

// File: rtl/morse_lut.sv
// Combinational ASCII to Morse lookup with lower-case folding; unsupported
// codes return a record with valid cleared.
module morse_lut
    import morse_pkg::*;
(
    input  logic [7:0] char_i,
    output morse_rec_t rec_o
);

    logic [7:0] up_s;

    // fold 'a'..'z' onto 'A'..'Z'
    always_comb begin
        if (char_i >= 8'h61 && char_i <= 8'h7A) begin
            up_s = char_i - 8'h20;
        end else begin
            up_s = char_i;
        end
    end

    // pattern table, first element in bit 4
    always_comb begin
        rec_o = '0;
        case (up_s)
            8'h20: begin
                rec_o.valid    = 1'b1;
                rec_o.is_space = 1'b1;
            end
            8'h41: rec_o = morse_sym(3'd2, 5'b01000);
            8'h42: rec_o = morse_sym(3'd4, 5'b10000);
            8'h43: rec_o = morse_sym(3'd4, 5'b10100);
            8'h44: rec_o = morse_sym(3'd3, 5'b10000);
            8'h45: rec_o = morse_sym(3'd1, 5'b00000);
            8'h46: rec_o = morse_sym(3'd4, 5'b00100);
            8'h47: rec_o = morse_sym(3'd3, 5'b11000);
            8'h48: rec_o = morse_sym(3'd4, 5'b00000);
            8'h49: rec_o = morse_sym(3'd2, 5'b00000);
            8'h4A: rec_o = morse_sym(3'd4, 5'b01110);
            8'h4B: rec_o = morse_sym(3'd3, 5'b10100);
            8'h4C: rec_o = morse_sym(3'd4, 5'b01000);
            8'h4D: rec_o = morse_sym(3'd2, 5'b11000);
            8'h4E: rec_o = morse_sym(3'd2, 5'b10000);
            8'h4F: rec_o = morse_sym(3'd3, 5'b11100);
            8'h50: rec_o = morse_sym(3'd4, 5'b01100);
            8'h51: rec_o = morse_sym(3'd4, 5'b11010);
            8'h52: rec_o = morse_sym(3'd3, 5'b01000);
            8'h53: rec_o = morse_sym(3'd3, 5'b00000);
            8'h54: rec_o = morse_sym(3'd1, 5'b10000);
            8'h55: rec_o = morse_sym(3'd3, 5'b00100);
            8'h56: rec_o = morse_sym(3'd4, 5'b00010);
            8'h57: rec_o = morse_sym(3'd3, 5'b01100);
            8'h58: rec_o = morse_sym(3'd4, 5'b10010);
            8'h59: rec_o = morse_sym(3'd4, 5'b10110);
            8'h5A: rec_o = morse_sym(3'd4, 5'b11000);
            8'h30: rec_o = morse_sym(3'd5, 5'b11111);
            8'h31: rec_o = morse_sym(3'd5, 5'b01111);
            8'h32: rec_o = morse_sym(3'd5, 5'b00111);
            8'h33: rec_o = morse_sym(3'd5, 5'b00011);
            8'h34: rec_o = morse_sym(3'd5, 5'b00001);
            8'h35: rec_o = morse_sym(3'd5, 5'b00000);
            8'h36: rec_o = morse_sym(3'd5, 5'b10000);
            8'h37: rec_o = morse_sym(3'd5, 5'b11000);
            8'h38: rec_o = morse_sym(3'd5, 5'b11100);
            8'h39: rec_o = morse_sym(3'd5, 5'b11110);
            default: rec_o = '0;
        endcase
    end

endmodule

// File: rtl/morse_keyer.sv
// Morse keyer: accepts one ASCII character per valid/ready handshake and plays
// it as unit-timed on/off keying on key_out.
module morse_keyer
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES = 4,
    parameter int LETTER_GAP  = 3,
    parameter int WORD_GAP    = 7,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       char_valid,
    input  logic [7:0] char_in,
    output logic       char_ready,
    output logic       key_out,
    output logic       busy,
    output logic       letter_done,
    output logic       bad_char
);

    localparam logic [CNT_W-1:0] DOT_LD  = CNT_W'(DOT_UNITS * UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DASH_LD = CNT_W'(DASH_UNITS * UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] EGAP_LD = CNT_W'(ELEM_GAP_UNITS * UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LGAP_LD = CNT_W'(LETTER_GAP * UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] WGAP_LD = CNT_W'((WORD_GAP - LETTER_GAP) * UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0] shreg_q, shreg_d;
    logic [2:0] elems_q, elems_d;
    morse_rec_t rec_q, rec_d, lut_rec_s;
    logic       key_q, key_d;
    logic       done_q, done_d;
    logic       bad_q, bad_d;
    logic       accept_s;

    morse_lut u_lut (
        .char_i (char_in),
        .rec_o  (lut_rec_s)
    );

    assign char_ready  = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign accept_s    = char_valid && (state_q == IDLE);
    assign key_out     = key_q;
    assign letter_done = done_q;
    assign bad_char    = bad_q;

    // next-state, timing counter and element shifter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        elems_d = elems_q;
        rec_d   = rec_q;
        bad_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d = LOAD;
                    rec_d   = lut_rec_s;
                    bad_d   = !lut_rec_s.valid;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                if (!rec_q.valid) begin
                    state_d = IDLE;
                end else if (rec_q.is_space) begin
                    state_d = WORD;
                    cnt_d   = WGAP_LD;
                end else begin
                    state_d = MARK;
                    shreg_d = rec_q.pattern;
                    elems_d = rec_q.len;
                    cnt_d   = rec_q.pattern[4] ? DASH_LD : DOT_LD;
                end
            end
            MARK: begin
                if (cnt_q != CNT_ZERO) begin
                    cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                end else if (elems_q > 3'd1) begin
                    state_d = SPACE;
                    cnt_d   = EGAP_LD;
                    elems_d = elems_q - 3'd1;
                end else begin
                    state_d = GAP;
                    cnt_d   = LGAP_LD;
                end
            end
            SPACE: begin
                if (cnt_q != CNT_ZERO) begin
                    cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    state_d = MARK;
                    shreg_d = {shreg_q[3:0], 1'b0};
                    cnt_d   = shreg_q[3] ? DASH_LD : DOT_LD;
                end
            end
            GAP, WORD: begin
                if (cnt_q != CNT_ZERO) begin
                    cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
        // outputs are registered, so derive them from the state being entered
        key_d  = (state_d == MARK);
        done_d = ((state_d == GAP) || (state_d == WORD)) && (cnt_d == CNT_ZERO);
    end

    // state and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= CNT_ZERO;
            shreg_q <= 5'd0;
            elems_q <= 3'd0;
            rec_q   <= '0;
            key_q   <= 1'b0;
            done_q  <= 1'b0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            elems_q <= elems_d;
            rec_q   <= rec_d;
            key_q   <= key_d;
            done_q  <= done_d;
            bad_q   <= bad_d;
        end
    end

endmodule

// File: tb/tb_morse_keyer.sv
// Self-checking bench for morse_keyer: table of characters with dot/dash
// strings expanded into expected per-cycle waveforms, plus streaming and reset cases.
module tb_morse_keyer;

    localparam int U = 4;

    logic       clk;
    logic       rst_n;
    logic       char_valid;
    logic [7:0] char_in;
    logic       char_ready;
    logic       key_out;
    logic       busy;
    logic       letter_done;
    logic       bad_char;

    int n_checks = 0;
    int n_fail   = 0;

    morse_keyer #(.UNIT_CYCLES(U), .LETTER_GAP(3), .WORD_GAP(7), .CNT_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .char_valid  (char_valid),
        .char_in     (char_in),
        .char_ready  (char_ready),
        .key_out     (key_out),
        .busy        (busy),
        .letter_done (letter_done),
        .bad_char    (bad_char)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  ch;
        logic [39:0] code;   // '.'/'-' bytes, first element in the highest non-zero byte
        logic        bad;
        logic        sp;
    } vec_t;

    vec_t       vecs[18];
    vec_t       msg_q[$];
    logic [4:0] exp_q[$];    // {ready, busy, key, letter_done, bad}
    int         exp_ld;

    function automatic vec_t mk(input logic [7:0] ch, input string code, input logic bad, input logic sp);
        vec_t v;
        v.ch   = ch;
        v.code = '0;
        for (int i = 0; i < code.len(); i++) begin
            v.code = {v.code[31:0], code[i]};
        end
        v.bad  = bad;
        v.sp   = sp;
        return v;
    endfunction

    task automatic check(input string name, input int cyc, input logic [4:0] act, input logic [4:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got {rdy,busy,key,done,bad}=%b expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic push_n(input int n, input logic key, input logic last_done);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({1'b0, 1'b1, key, (last_done && i == n - 1), 1'b0});
        end
    endtask

    // expected waveform from the accept (IDLE) cycle to the end of the letter/word gap
    task automatic build_exp(input vec_t v);
        logic first;
        logic [7:0] e;
        exp_q.push_back(5'b10000);
        exp_q.push_back({3'b010, 1'b0, v.bad});
        if (v.bad) begin
        end else if (v.sp) begin
            push_n(4 * U, 1'b0, 1'b1);
            exp_ld++;
        end else begin
            first = 1'b1;
            for (int b = 4; b >= 0; b--) begin
                e = v.code[b*8 +: 8];
                if (e == 8'h2E || e == 8'h2D) begin
                    if (!first) push_n(U, 1'b0, 1'b0);
                    push_n((e == 8'h2D) ? 3 * U : U, 1'b1, 1'b0);
                    first = 1'b0;
                end
            end
            push_n(3 * U, 1'b0, 1'b1);
            exp_ld++;
        end
    endtask

    // stream msg_q with valid held high; caller is #1 after a posedge in IDLE
    task automatic run_msg(input string name);
        int idx;
        int nld;
        logic acc;
        exp_q.delete();
        exp_ld = 0;
        foreach (msg_q[k]) build_exp(msg_q[k]);
        exp_q.push_back(5'b10000);
        idx = 0;
        nld = 0;
        char_valid = 1'b1;
        char_in    = msg_q[0].ch;
        for (int i = 0; i < exp_q.size(); i++) begin
            check(name, i, {char_ready, busy, key_out, letter_done, bad_char}, exp_q[i]);
            if (letter_done) nld++;
            acc = char_ready && char_valid;
            if (i < exp_q.size() - 1) begin
                @(posedge clk);
                #1;
                if (acc) begin
                    idx++;
                    if (idx < msg_q.size()) char_in = msg_q[idx].ch;
                    else char_valid = 1'b0;
                end
            end
        end
        char_valid = 1'b0;
        n_checks++;
        if (nld != exp_ld) begin
            n_fail++;
            $display("FAIL %s_done_count: got %0d expected %0d", name, nld, exp_ld);
        end
    endtask

    initial begin
        vecs[0]  = mk(8'h45, ".",     1'b0, 1'b0);  // E
        vecs[1]  = mk(8'h41, ".-",    1'b0, 1'b0);  // A
        vecs[2]  = mk(8'h61, ".-",    1'b0, 1'b0);  // a
        vecs[3]  = mk(8'h54, "-",     1'b0, 1'b0);  // T
        vecs[4]  = mk(8'h30, "-----", 1'b0, 1'b0);  // 0
        vecs[5]  = mk(8'h35, ".....", 1'b0, 1'b0);  // 5
        vecs[6]  = mk(8'h51, "--.-",  1'b0, 1'b0);  // Q
        vecs[7]  = mk(8'h7A, "--..",  1'b0, 1'b0);  // z
        vecs[8]  = mk(8'h20, "",      1'b0, 1'b1);  // space
        vecs[9]  = mk(8'h23, "",      1'b1, 1'b0);  // #
        vecs[10] = mk(8'h40, "",      1'b1, 1'b0);  // @
        vecs[11] = mk(8'h5B, "",      1'b1, 1'b0);  // [
        vecs[12] = mk(8'h60, "",      1'b1, 1'b0);  // `
        vecs[13] = mk(8'h7B, "",      1'b1, 1'b0);  // {
        vecs[14] = mk(8'h2F, "",      1'b1, 1'b0);  // /
        vecs[15] = mk(8'h3A, "",      1'b1, 1'b0);  // :
        vecs[16] = mk(8'h00, "",      1'b1, 1'b0);
        vecs[17] = mk(8'hC1, "",      1'b1, 1'b0);  // 'A' with bit 7 set

        rst_n      = 1'b0;
        char_valid = 1'b0;
        char_in    = 8'h00;
        #1;
        check("reset", 0, {char_ready, busy, key_out, letter_done, bad_char}, 5'b10000);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int v = 0; v < 18; v++) begin
            msg_q.delete();
            msg_q.push_back(vecs[v]);
            run_msg($sformatf("char_%02h", vecs[v].ch));
        end

        msg_q.delete();
        msg_q.push_back(mk(8'h53, "...", 1'b0, 1'b0));
        msg_q.push_back(mk(8'h4F, "---", 1'b0, 1'b0));
        msg_q.push_back(mk(8'h53, "...", 1'b0, 1'b0));
        run_msg("sos_stream");

        // abort a 'T' dash in its 6th high cycle with an asynchronous reset
        char_valid = 1'b1;
        char_in    = 8'h54;
        @(posedge clk);
        #1;
        char_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("dash_before_reset", 0, {char_ready, busy, key_out, letter_done, bad_char}, 5'b01100);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 0, {char_ready, busy, key_out, letter_done, bad_char}, 5'b10000);
        @(posedge clk);
        #1;
        check("held_reset", 0, {char_ready, busy, key_out, letter_done, bad_char}, 5'b10000);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("after_reset", 0, {char_ready, busy, key_out, letter_done, bad_char}, 5'b10000);
        msg_q.delete();
        msg_q.push_back(vecs[0]);
        run_msg("e_after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/morse_keyer.md
Name: morse_keyer

Overview:
- Sequences one ASCII character at a time into Morse on/off keying with exact unit timing: dot, dash, intra-letter gap, letter gap, word gap.
- Sits directly downstream of the message ROM sequencer and consumes its character stream through a valid/ready handshake.
- Drives the key line for the LED/buzzer and tells the upstream sequencer when the next character may be sent.

Parameters:
- UNIT_CYCLES, 4, clock cycles per Morse unit (>=1).
- LETTER_GAP, 3, units of key-low after the last element of a letter.
- WORD_GAP, 7, total units between words; a space adds WORD_GAP-LETTER_GAP units.
- CNT_W, 8, width of the unit-cycle down-counter; must hold 3*UNIT_CYCLES-1 and (WORD_GAP-LETTER_GAP)*UNIT_CYCLES-1.

Ports:
- clk  in  1  system clock, all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- char_valid  in  1  char_in holds a character to send.
- char_in  in  8  ASCII character.
- char_ready  out  1  keyer can accept; high only in IDLE.
- key_out  out  1  registered Morse key, 1 = tone on.
- busy  out  1  high in any state other than IDLE.
- letter_done  out  1  one-cycle pulse when the letter gap or word gap completes.
- bad_char  out  1  one-cycle pulse when an unsupported character is dropped.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, key_out=0, letter_done=0, bad_char=0, counters 0. Reset asserted mid-character aborts it: key_out drops at once, char_ready=1 one cycle after rst_n rises.
- Handshake: accept when char_valid && char_ready in cycle T; char_in is sampled only in that cycle. char_ready is combinational from state (IDLE). valid held while busy has no effect.
- Character set:
  - 'A'-'Z' and 'a'-'z' (folded to upper case) and '0'-'9' map to a pattern of at most 5 elements, sent MSB first, 1 = dash, plus a 3-bit length.
  - ' ' (0x20) is a word gap.
  - Every other character is unsupported.
- States and transitions:
  - IDLE: on accept go to LOAD.
  - LOAD (T+1): look up the pattern.
    - Unsupported: bad_char=1 this cycle, go to IDLE; ready at T+2.
    - Space: go to WORD.
    - Otherwise load the element shift register and element count, go to MARK.
  - MARK: key_out=1 for exactly UNIT_CYCLES cycles (dot) or 3*UNIT_CYCLES cycles (dash). Registered, so key_out is high from T+2. If elements remain, go to SPACE; else go to GAP.
  - SPACE: key_out=0 for UNIT_CYCLES cycles, shift to the next element, go to MARK.
  - GAP: key_out=0 for LETTER_GAP*UNIT_CYCLES cycles. letter_done pulses in the last cycle. Go to IDLE.
  - WORD: key_out=0 for (WORD_GAP-LETTER_GAP)*UNIT_CYCLES cycles. letter_done pulses in the last cycle. Go to IDLE.
- Timing counter: a single down-counter loaded with N*UNIT_CYCLES-1 on entry to each timed state; the state exits when the counter is 0. Counter underflow is never permitted.
- Back-to-back characters: if valid is already high when IDLE is re-entered, it is accepted in the first IDLE cycle. This gives a 2-cycle overhead per character (IDLE + LOAD) beyond the unit timing.
- busy = (state != IDLE); letter_done and bad_char are never high together.

Decomposition:
- morse_pkg holds:
  - state enum: IDLE, LOAD, MARK, SPACE, GAP, WORD;
  - constants DOT_UNITS=1, DASH_UNITS=3, ELEM_GAP_UNITS=1, MAX_ELEMS=5;
  - the pattern/length record typedef.
- Sub-module morse_lut: combinational ASCII to {valid, is_space, len[2:0], pattern[4:0]}, including case folding. It is verified standalone over all 256 codes.

Test Plan:
- 'E', UNIT_CYCLES=4, valid at T -> key_out high T+2..T+5 (4 cycles), low 12 cycles, letter_done at the last low cycle, char_ready next cycle.
- 'A' -> key high 4, low 4, high 12, low 12, then letter_done. Lowercase 'a' gives an identical waveform.
- "SOS" streamed with valid held high -> three letters separated by 12-cycle gaps plus 2 overhead cycles; exactly 3 letter_done pulses.
- ' ' -> key_out stays 0 for 16 cycles, letter_done pulses once, bad_char stays 0.
- '#' (0x23) -> bad_char pulse at T+1, key_out never rises, char_ready=1 at T+2.
- rst_n low during the 6th cycle of a dash ('T') -> key_out 0 asynchronously; after release the keyer accepts a fresh 'E' with correct timing.
